// File: rtl/shift_pkg.sv
// Shared types and encoding constants for the shift issue path.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SRL  = 2'b00,
        SLL  = 2'b01,
        SRA  = 2'b10,
        PASS = 2'b11
    } shift_type_t;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]    a;
        logic [SHAMT_W-1:0] shamt;
        shift_type_t        stype;
        logic [4:0]         rd;
        logic               illegal;
    } shift_entry_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational shift decode: shift amount, shift type and illegal flag.
// Optional funct7 legality check is enabled by defining SHIFT_ILLEGAL_CHK_EN.
module shift_decode
    import shift_pkg::*;
(
    input  logic [31:0]        instr_i,
    input  logic [XLEN-1:0]    rs2_val_i,
    output logic [SHAMT_W-1:0] shamt_o,
    output shift_type_t        type_o,
    output logic               illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_shift;
    logic       unused_bits;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Shift-class means a shift opcode AND a shift funct3; ADD/SUB etc. pass through.
    assign is_shift = ((opcode == OPC_OP) || (opcode == OPC_OPIMM)) &&
                      ((funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SR));

    assign unused_bits = ^{rs2_val_i[XLEN-1:SHAMT_W], instr_i[11:7], instr_i[19:15],
                           funct7[6], funct7[4:0]};

    always_comb begin
        type_o    = PASS;
        illegal_o = 1'b0;
        shamt_o   = (opcode == OPC_OP) ? rs2_val_i[SHAMT_W-1:0] : instr_i[24:20];
        if (is_shift) begin
            if (funct3 == FUNCT3_SLL) begin
                type_o = SLL;
            end else begin
                type_o = instr_i[30] ? SRA : SRL;
            end
        end
`ifdef SHIFT_ILLEGAL_CHK_EN
        if (is_shift && (((funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT)) ||
                         ((funct7 == FUNCT7_ALT) && (funct3 == FUNCT3_SLL)))) begin
            illegal_o = 1'b1;
            type_o    = PASS;
        end
`endif
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decode on accept into a main + skid register pair.
// in_ready comes straight from the skid-valid flop. See shift_decode for SHIFT_ILLEGAL_CHK_EN.
module shift_issue_stage
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_rs1_val,
    input  logic [XLEN-1:0]    in_rs2_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_a,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [1:0]         out_type,
    output logic [4:0]         out_rd,
    output logic               out_illegal
);

    shift_entry_t main_q, main_d;
    shift_entry_t skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;

    logic [SHAMT_W-1:0] dec_shamt;
    shift_type_t        dec_type;
    logic               dec_illegal;
    shift_entry_t       new_entry;
    logic               accept;

    shift_decode u_decode (
        .instr_i   (in_instr),
        .rs2_val_i (in_rs2_val),
        .shamt_o   (dec_shamt),
        .type_o    (dec_type),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        new_entry.a       = in_rs1_val;
        new_entry.shamt   = dec_shamt;
        new_entry.stype   = dec_type;
        new_entry.rd      = in_instr[11:7];
        new_entry.illegal = dec_illegal;
    end

    assign accept = in_valid && !skid_valid_q && !flush;

    // Skid can only be valid while main is valid, so it always refills main first.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_a       = main_q.a;
    assign out_shamt   = main_q.shamt;
    assign out_type    = main_q.stype;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: inputs driven and outputs sampled on the falling edge.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [4:0]  out_shamt;
    logic [1:0]  out_type;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_shamt   (out_shamt),
        .out_type    (out_type),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid   = v;
        in_instr   = instr;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #2;
        vectors++;
        if ({out_valid, in_ready, out_a, out_shamt, out_type, out_rd, out_illegal} !==
            {1'b0, 1'b1, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got v=%b rdy=%b a=%h sh=%0d t=%b rd=%0d il=%b want v=0 rdy=1 rest 0",
                     out_valid, in_ready, out_a, out_shamt, out_type, out_rd, out_illegal);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_slli;
        out_ready = 1'b0;
        drive(1'b1, 32'h00309293, 32'h0000_00F1, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vectors++;
        if ({out_valid, out_type, out_shamt, out_a, out_rd, out_illegal} !==
            {1'b1, 2'b01, 5'd3, 32'h0000_00F1, 5'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL slli got v=%b t=%b sh=%0d a=%h rd=%0d want v=1 t=01 sh=3 a=f1 rd=5",
                     out_valid, out_type, out_shamt, out_a, out_rd);
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL slli_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reg_forms;
        out_ready = 1'b1;
        drive(1'b1, 32'h4020D1B3, 32'h8000_0001, 32'hFFFF_FF24);
        @(negedge clk);
        vectors++;
        if ({out_valid, out_type, out_shamt, out_a, out_rd} !==
            {1'b1, 2'b10, 5'd4, 32'h8000_0001, 5'd3}) begin
            miscompares++;
            $display("FAIL sra got v=%b t=%b sh=%0d a=%h rd=%0d want v=1 t=10 sh=4 a=80000001 rd=3",
                     out_valid, out_type, out_shamt, out_a, out_rd);
        end
        drive(1'b1, 32'h0020D1B3, 32'h1234_5678, 32'h0000_003F);
        @(negedge clk);
        vectors++;
        if ({out_valid, out_type, out_shamt, out_a} !== {1'b1, 2'b00, 5'd31, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL srl_reg got v=%b t=%b sh=%0d a=%h want v=1 t=00 sh=31 a=12345678",
                     out_valid, out_type, out_shamt, out_a);
        end
        drive(1'b1, 32'h002082B3, 32'hCAFE_0000, 32'h0);
        @(negedge clk);
        vectors++;
        if ({out_valid, out_type, out_rd, out_illegal} !== {1'b1, 2'b11, 5'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL add_pass got v=%b t=%b rd=%0d il=%b want v=1 t=11 rd=5 il=0",
                     out_valid, out_type, out_rd, out_illegal);
        end
        drive(1'b1, 32'h02309293, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vectors++;
`ifdef SHIFT_ILLEGAL_CHK_EN
        if ({out_valid, out_type, out_illegal} !== {1'b1, 2'b11, 1'b1}) begin
            miscompares++;
            $display("FAIL funct7_bad got v=%b t=%b il=%b want v=1 t=11 il=1",
                     out_valid, out_type, out_illegal);
        end
`else
        if ({out_valid, out_type, out_illegal} !== {1'b1, 2'b01, 1'b0}) begin
            miscompares++;
            $display("FAIL funct7_bad got v=%b t=%b il=%b want v=1 t=01 il=0",
                     out_valid, out_type, out_illegal);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 32'h0010D293, 32'h11, 32'h0);
        @(negedge clk);
        drive(1'b1, 32'h0020D293, 32'h22, 32'h0);
        vectors++;
        if ({in_ready, out_valid, out_shamt} !== {1'b1, 1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL bp_first got rdy=%b v=%b sh=%0d want rdy=1 v=1 sh=1", in_ready, out_valid, out_shamt);
        end
        @(negedge clk);
        drive(1'b1, 32'h0030D293, 32'h33, 32'h0);
        vectors++;
        if ({in_ready, out_valid, out_shamt} !== {1'b0, 1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL bp_full got rdy=%b v=%b sh=%0d want rdy=0 v=1 sh=1", in_ready, out_valid, out_shamt);
        end
        @(negedge clk);
        vectors++;
        if ({in_ready, out_shamt, out_a} !== {1'b0, 5'd1, 32'h11}) begin
            miscompares++;
            $display("FAIL bp_stable got rdy=%b sh=%0d a=%h want rdy=0 sh=1 a=11", in_ready, out_shamt, out_a);
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_shamt, out_a} !== {1'b1, 1'b1, 5'd2, 32'h22}) begin
            miscompares++;
            $display("FAIL bp_second got rdy=%b v=%b sh=%0d a=%h want rdy=1 v=1 sh=2 a=22",
                     in_ready, out_valid, out_shamt, out_a);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vectors++;
        if ({out_valid, out_shamt, out_a} !== {1'b1, 5'd3, 32'h33}) begin
            miscompares++;
            $display("FAIL bp_third got v=%b sh=%0d a=%h want v=1 sh=3 a=33", out_valid, out_shamt, out_a);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_empty got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00009293 | (i << 20), 32'h100 + i, 32'h0);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_ready[%0d] got rdy=%b want 1", i, in_ready);
            end
            @(negedge clk);
            vectors++;
            if ({out_valid, out_type, out_shamt, out_a} !== {1'b1, 2'b01, i[4:0], 32'h100 + i}) begin
                miscompares++;
                $display("FAIL stream_out[%0d] got v=%b t=%b sh=%0d a=%h want v=1 t=01 sh=%0d a=%h",
                         i, out_valid, out_type, out_shamt, out_a, i, 32'h100 + i);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, 32'h0010D293, 32'hA, 32'h0);
        @(negedge clk);
        drive(1'b1, 32'h0020D293, 32'hB, 32'h0);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'h0030D293, 32'hC, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL flush_full got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_nothing got v=%b want 0", out_valid);
        end
        flush = 1'b1;
        drive(1'b1, 32'h0010D293, 32'hD, 32'h0);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_cycle_ready got rdy=%b want 1", in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(1'b1, 32'h0010D293, 32'h5, 32'h0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, in_ready, out_a, out_shamt} !== {1'b0, 1'b1, 32'h0, 5'd0}) begin
            miscompares++;
            $display("FAIL async_reset got v=%b rdy=%b a=%h sh=%0d want v=0 rdy=1 a=0 sh=0",
                     out_valid, in_ready, out_a, out_shamt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_slli();
        test_reg_forms();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Issue stage directly upstream of the barrel shifter in the RISC-V execute path. Accepts decoded shift-class instructions with register operands over a valid/ready handshake, extracts the shift amount and shift type, and registers them into a two-entry skid buffer. The stage drives the shifter's operand, shamt and type inputs. It absorbs execute-side backpressure without a combinational ready path.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- SHAMT_W, 5: shift-amount width, log2(XLEN).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush; drops all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; equals NOT skid_valid (registered)
- in_instr  in  32  raw instruction word
- in_rs1_val  in  XLEN  rs1 operand value
- in_rs2_val  in  XLEN  rs2 operand value (R-type shamt source)
- out_valid  out  1  entry presented to shifter
- out_ready  in  1  shifter/execute accepts
- out_a  out  XLEN  value to shift (rs1)
- out_shamt  out  SHAMT_W  shift amount
- out_type  out  2  00 srl, 01 sll, 10 sra, 11 pass-through
- out_rd  out  5  destination register, instr[11:7]
- out_illegal  out  1  illegal shift encoding (macro-dependent)

## Operation
- Handshake: transfer on valid AND ready, on both sides.
- Decode on accept. The opcode is instr[6:0], and only two opcodes are shift-class:
  - 0110011 (OP): shamt = rs2_val[4:0].
  - 0010011 (OP-IMM): shamt = instr[24:20].
- funct3 = instr[14:12]:
  - 001 gives sll (01).
  - 101 gives srl (00) if instr[30]=0, or sra (10) if instr[30]=1.
- Any other opcode/funct3 gives type 11 (pass-through; the shifter returns a unchanged).
- Storage: main register (what the outputs present) plus one skid register.
  - Accept while main is empty or draining: the entry goes to main.
  - Accept while main is held (out_valid AND NOT out_ready): the entry goes to skid.
  - When main drains and skid is valid: skid moves to main and skid clears.
- in_ready = NOT skid_valid, driven from a flop, never from out_ready.
- Ordering is strictly FIFO.
- Output fields are stable while out_valid=1 AND out_ready=0.
- flush: at the next edge both entries are invalidated. An in_valid in the flush cycle is dropped, and in_ready still reads 1 that cycle.

## Timing
- Latency: accept at edge N, out_valid=1 after edge N.
- Throughput: 1 per cycle with out_ready held at 1.
- With out_ready=0, the stage accepts 2 entries, then in_ready=0 from the following cycle.
- Simultaneous accept and drain with skid empty: the new entry replaces main, and there is no bubble.
- Simultaneous accept and drain with skid full: cannot happen, because in_ready=0.
- Reset values: out_valid=0, skid_valid=0, in_ready=1, out_a=0, out_shamt=0, out_type=00, out_rd=0, out_illegal=0.
- Reset mid-operation discards all entries asynchronously.
- flush and rst_n both active: reset wins.

## Configuration
- SHIFT_ILLEGAL_CHK_EN, when defined:
  - out_illegal=1 for shift-class encodings where instr[31:25] is neither 0000000 nor 0100000, or is 0100000 with funct3=001.
  - For those entries out_type=11 and the entry still flows.
  - out_illegal=0 for non-shift-class encodings.
- When not defined: out_illegal is tied 0, and only instr[30] is inspected.

## Structure
- Shared package shift_pkg holds:
  - shift_type_t enum: SRL=2'b00, SLL=2'b01, SRA=2'b10, PASS=2'b11.
  - Opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011.
  - FUNCT3_SLL=3'b001 and FUNCT3_SR=3'b101.
  - FUNCT7_BASE and FUNCT7_ALT.
- One combinational sub-module, shift_decode (instr, rs2_val → shamt, type, illegal), instantiated once ahead of the skid buffer.

## Test plan
- SLLI x5,x1,3 (0x00309293), rs1=0x0000_00F1 → out_type=01, out_shamt=3, out_a=0xF1, out_rd=5, out_valid one cycle after accept.
- SRA x3,x1,x2 (0x4020D1B3), rs2=0xFFFF_FF24 → out_type=10, out_shamt=4 (rs2 low 5 bits only).
- out_ready=0, three back-to-back SRLI (shamt 1,2,3) → in_ready drops after two accepts. After releasing out_ready, outputs are shamt 1,2,3 in order and the third is accepted with no loss.
- Stream 8 entries with out_ready=1 → 8 transfers in 8 consecutive cycles, no bubbles.
- Two entries held, then flush=1 with in_valid=1 → out_valid=0 next cycle, nothing emitted, in_ready=1.
- With SHIFT_ILLEGAL_CHK_EN defined: SLLI with instr[31:25]=0000001 → out_illegal=1, out_type=11. Without the macro the same encoding gives out_illegal=0, out_type=01.
